cic_decim: RTL and testbench
============================

# cic_decim

Programmable-rate, 3-stage CIC decimation filter for the receive DSP chain. Accepts 12-bit signed samples qualified by `nd` and decimates by a runtime-loadable rate of 4..4096. Outputs 16-bit signed, gain-normalised samples with a one-cycle `rdy` strobe. Sits between the ADC front end and the downstream half-band/FIR stages.

## Interface
- `N_STAGES`, 3: integrator/comb stage count (fixed; widths below assume 3)
- `IN_W`, 12: input sample width
- `OUT_W`, 16: output sample width
- `ACC_W`, 48: internal width = IN_W + N_STAGES*12
---
- `clk`  in  1  single clock; all logic on rising edge
- `reset_n`  in  1  one clock; reset is asynchronous and active-low
- `sclr`  in  1  synchronous clear, active-high
- `nd`  in  1  new data; `din` valid this cycle
- `din`  in  12  signed two's-complement input sample
- `rate_we`  in  1  load `rate` into active rate register
- `rate`  in  13  unsigned decimation factor
- `rfd`  out  1  ready for data
- `rdy`  out  1  one-cycle strobe, `dout` valid
- `dout`  out  16  signed decimated output, held between strobes

## Operation
- Active rate R: loaded on `rate_we`; values <4 load 4, >4096 load 4096. Reset value 4.
- L = ceil(log2 R), range 2..12, computed when R is loaded and registered with it.
- Integrators (ACC_W, wrap modulo 2^48), updated only on accepted samples (`nd`=1 and `rfd`=1): i1 += sext(din); i2 += i1(old); i3 += i2(old). The pipelined cascade is required.
- Decimation counter 0..R-1, advances per accepted sample. The sample taking it from R-1 to 0 is the decimation sample.
- Comb chain runs once per decimation: c1 = i3 - d1; c2 = c1 - d2; c3 = c2 - d3. Each d register holds its stage's previous input. All arithmetic is mod 2^48.
- Scaling: dout = (c3 >>> (3L-4))[15:0]. Arithmetic shift, truncation, no rounding, no saturation.
- Gain is exactly 1 for power-of-two R, i.e. dout = din<<4 at DC. For other R, gain is (R/2^L)^3 < 1.
- `sclr`=1: zero integrators, combs, delays, counter, pipeline valids, `dout`, and `rdy`. R and L are retained.
- `rate_we`=1: load R/L and perform the same clear as `sclr`.
- `reset_n`=0: all state cleared asynchronously, R=4, L=2, `rfd`=0.
- Priority, highest first: `reset_n`, then `sclr`/`rate_we`, then `nd`. A sample with `nd` in a `sclr` or `rate_we` cycle is discarded.
- `rfd` is 0 in reset and 1 from the first clock edge after `reset_n` deasserts. `nd` while `rfd`=0 is ignored.

## Timing
- Reset values: `rfd`=0, `rdy`=0, `dout`=0.
- Latency: the decimation sample is accepted at edge k.
  - Comb stages register at edges k+1, k+2, k+3.
  - `dout`/`rdy` register at edge k+4. `rdy` is high for exactly the following cycle.
- Output rate: one `rdy` per R accepted samples. The `nd` duty cycle is arbitrary, and back-to-back `nd` every clock is supported.
- Pipeline tolerates a new decimation every R≥4 accepted samples without overlap.
- Clear mid-pipeline (`sclr`/`rate_we`) kills in-flight results. No `rdy` occurs until R new samples plus 4 clocks have elapsed.
- Transient: the first three outputs after clear may be partial. Outputs from the 4th `rdy` onward equal steady state for constant input.

## Test plan
- Reset then R=4 via `rate_we`, `din`=0x010, `nd` every 4th clock -> `rdy` every 16 clocks; from 4th `rdy` `dout`=0x0100.
- R=64, `din`=0x7FF constant, `nd` every clock -> `rdy` every 64 clocks, steady `dout`=0x7FF0; `din`=0x800 -> `dout`=0x8000.
- R=5, `din`=0x100 -> steady `dout` = (0x100*125<<4)>>>... = floor(0x1000*125/512) = 0x03E8.
- `sclr` pulse mid-frame with R=4 -> `rdy`/`dout` cleared next cycle; R kept; first new `rdy` exactly 4 clocks after 4th post-clear sample.
- `rate` write of 2 and 5000 -> behaves as R=4 and R=4096. `rate_we` coinciding with `nd` -> sample discarded, counter restarts.
- `reset_n` low mid-operation -> outputs zero immediately (asynchronously), `rfd`=0; after release R=4 defaults and `rfd`=1 next edge.

Source files
------------

// File: rtl/cic_decim.sv
//------------------------------------------------------------------------------
// cic_decim
//
// Programmable-rate 3-stage CIC decimation filter. Integrators run at the
// input sample rate (only on accepted samples), the comb chain runs once per
// decimation as a 3-deep pipeline, and the comb result is arithmetically
// shifted by 3*L-4 (L = ceil(log2 R)) to normalise the R^3 gain.
//
// Ports:
//   clk      in   system clock, rising edge
//   reset_n  in   asynchronous active-low reset
//   sclr     in   synchronous clear (keeps rate)
//   nd       in   din valid this cycle
//   din      in   IN_W-bit signed input sample
//   rate_we  in   load rate (clamped to 4..4096) and clear datapath
//   rate     in   13-bit unsigned decimation factor
//   rfd      out  ready for data (0 only while/just after reset)
//   rdy      out  one-cycle strobe, dout valid
//   dout     out  OUT_W-bit signed decimated output, held between strobes
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module cic_decim #(
  parameter int N_STAGES = 3,
  parameter int IN_W     = 12,
  parameter int OUT_W    = 16,
  parameter int ACC_W    = 48
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             sclr,
  input  logic             nd,
  input  logic [IN_W-1:0]  din,
  input  logic             rate_we,
  input  logic [12:0]      rate,
  output logic             rfd,
  output logic             rdy,
  output logic [OUT_W-1:0] dout
);

  localparam int RATE_W = 13;
  localparam int CNT_W  = 12;
  localparam logic [RATE_W-1:0] RATE_MIN = 13'd4;
  localparam logic [RATE_W-1:0] RATE_MAX = 13'd4096;

  // Saturate a requested rate into the supported 4..4096 range.
  function automatic logic [RATE_W-1:0] clamp_rate(input logic [RATE_W-1:0] r);
    logic [RATE_W-1:0] res;
    if (r < RATE_MIN) begin
      res = RATE_MIN;
    end else if (r > RATE_MAX) begin
      res = RATE_MAX;
    end else begin
      res = r;
    end
    return res;
  endfunction

  // Smallest L with 2^L >= r, for r already clamped to 4..4096.
  function automatic logic [3:0] ceil_log2(input logic [RATE_W-1:0] r);
    logic [3:0] res;
    res = 4'd0;
    for (int i = 0; i < RATE_W - 1; i++) begin
      if ((13'd1 << i) < r) begin
        res = 4'(i + 1);
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  // State registers
  logic              rfd_q;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [3:0]        l_q, l_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [ACC_W-1:0]  c1_q, c1_d, c2_q, c2_d, c3_q, c3_d;
  logic [ACC_W-1:0]  d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic              dec_q, dec_d, v1_q, v1_d, v2_q, v2_d, v3_q, v3_d;
  logic              rdy_q, rdy_d;
  logic [OUT_W-1:0]  dout_q, dout_d;

  // Combinational helpers
  logic             clr_s;
  logic             accept_s;
  logic             last_s;
  logic [ACC_W-1:0] din_ext_s;
  logic [5:0]       shift_s;
  logic [RATE_W-1:0] rate_clamped_s;

  assign clr_s          = sclr | rate_we;
  // A sample arriving in a clear cycle is dropped: clear has priority over nd.
  assign accept_s       = nd & rfd_q & ~clr_s;
  assign last_s         = (cnt_q == CNT_W'(rate_q - 13'd1));
  assign din_ext_s      = ACC_W'($signed(din));
  assign shift_s        = 6'(N_STAGES) * {2'b00, l_q} - 6'd4;
  assign rate_clamped_s = clamp_rate(rate);

  // Next-state logic: rate load/clear, integrators, counter and comb pipeline.
  always_comb begin
    rate_d = rate_q;
    l_d    = l_q;
    cnt_d  = cnt_q;
    i1_d   = i1_q;
    i2_d   = i2_q;
    i3_d   = i3_q;
    dec_d  = 1'b0;
    v1_d   = dec_q;
    v2_d   = v1_q;
    v3_d   = v2_q;
    rdy_d  = v3_q;

    // Comb stage 1 samples i3 the edge after the decimation sample landed.
    if (dec_q) begin
      c1_d = i3_q - d1_q;
      d1_d = i3_q;
    end else begin
      c1_d = c1_q;
      d1_d = d1_q;
    end

    if (v1_q) begin
      c2_d = c1_q - d2_q;
      d2_d = c1_q;
    end else begin
      c2_d = c2_q;
      d2_d = d2_q;
    end

    if (v2_q) begin
      c3_d = c2_q - d3_q;
      d3_d = c2_q;
    end else begin
      c3_d = c3_q;
      d3_d = d3_q;
    end

    // Truncating arithmetic shift; the low OUT_W bits are the output word.
    if (v3_q) begin
      dout_d = OUT_W'($signed(c3_q) >>> shift_s);
    end else begin
      dout_d = dout_q;
    end

    if (clr_s) begin
      if (rate_we) begin
        rate_d = rate_clamped_s;
        l_d    = ceil_log2(rate_clamped_s);
      end else begin
        rate_d = rate_q;
        l_d    = l_q;
      end
      cnt_d  = {CNT_W{1'b0}};
      i1_d   = {ACC_W{1'b0}};
      i2_d   = {ACC_W{1'b0}};
      i3_d   = {ACC_W{1'b0}};
      c1_d   = {ACC_W{1'b0}};
      c2_d   = {ACC_W{1'b0}};
      c3_d   = {ACC_W{1'b0}};
      d1_d   = {ACC_W{1'b0}};
      d2_d   = {ACC_W{1'b0}};
      d3_d   = {ACC_W{1'b0}};
      dec_d  = 1'b0;
      v1_d   = 1'b0;
      v2_d   = 1'b0;
      v3_d   = 1'b0;
      rdy_d  = 1'b0;
      dout_d = {OUT_W{1'b0}};
    end else if (accept_s) begin
      // Pipelined cascade: each stage adds the previous stage's old value.
      i1_d = i1_q + din_ext_s;
      i2_d = i2_q + i1_q;
      i3_d = i3_q + i2_q;
      if (last_s) begin
        cnt_d = {CNT_W{1'b0}};
        dec_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 12'd1;
        dec_d = 1'b0;
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State update with asynchronous reset to the default rate of 4.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rfd_q  <= 1'b0;
      rate_q <= 13'd4;
      l_q    <= 4'd2;
      cnt_q  <= {CNT_W{1'b0}};
      i1_q   <= {ACC_W{1'b0}};
      i2_q   <= {ACC_W{1'b0}};
      i3_q   <= {ACC_W{1'b0}};
      c1_q   <= {ACC_W{1'b0}};
      c2_q   <= {ACC_W{1'b0}};
      c3_q   <= {ACC_W{1'b0}};
      d1_q   <= {ACC_W{1'b0}};
      d2_q   <= {ACC_W{1'b0}};
      d3_q   <= {ACC_W{1'b0}};
      dec_q  <= 1'b0;
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      v3_q   <= 1'b0;
      rdy_q  <= 1'b0;
      dout_q <= {OUT_W{1'b0}};
    end else begin
      rfd_q  <= 1'b1;
      rate_q <= rate_d;
      l_q    <= l_d;
      cnt_q  <= cnt_d;
      i1_q   <= i1_d;
      i2_q   <= i2_d;
      i3_q   <= i3_d;
      c1_q   <= c1_d;
      c2_q   <= c2_d;
      c3_q   <= c3_d;
      d1_q   <= d1_d;
      d2_q   <= d2_d;
      d3_q   <= d3_d;
      dec_q  <= dec_d;
      v1_q   <= v1_d;
      v2_q   <= v2_d;
      v3_q   <= v3_d;
      rdy_q  <= rdy_d;
      dout_q <= dout_d;
    end
  end

  assign rfd  = rfd_q;
  assign rdy  = rdy_q;
  assign dout = dout_q;

endmodule

// File: tb/tb_cic_decim.sv
//------------------------------------------------------------------------------
// tb_cic_decim
//
// Self-checking bench for cic_decim. A reference model keeps every accepted
// sample since the last clear and evaluates each decimated output in closed
// form: the triple running sum after n samples is sum x_j*C(n-1-j,2), the
// comb is its third difference over multiples of R, then >>> (3*ceil(log2 R)-4).
// Every clock the model's expected rdy/dout (with exact k+4 latency and
// output hold) is compared against the DUT.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_cic_decim;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sclr;
  logic        nd;
  logic [11:0] din;
  logic        rate_we;
  logic [12:0] rate;
  logic        rfd;
  logic        rdy;
  logic [15:0] dout;

  always #5 clk = ~clk;

  cic_decim dut (
    .clk    (clk),
    .reset_n(reset_n),
    .sclr   (sclr),
    .nd     (nd),
    .din    (din),
    .rate_we(rate_we),
    .rate   (rate),
    .rfd    (rfd),
    .rdy    (rdy),
    .dout   (dout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  typedef struct {
    longint      due;
    logic [15:0] val;
  } pend_t;

  int          m_r   = 4;
  int          m_l   = 2;
  int          m_cnt = 0;
  int          m_dec = 0;
  int          m_x[$];
  pend_t       m_pend[$];
  logic [15:0] m_hold = 16'h0000;
  logic        m_rfd  = 1'b0;
  longint      cyc    = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Triple running sum value after idx*R samples (0 for idx <= 0).
  function automatic longint model_f(int idx);
    longint s = 0;
    longint n;
    if (idx <= 0) return 0;
    n = longint'(idx) * m_r;
    for (int j = 0; j < n && j < m_x.size(); j++) begin
      longint a;
      a = n - 1 - j;
      s += longint'(m_x[j]) * (a * (a - 1) / 2);
    end
    return s;
  endfunction

  function automatic logic [15:0] model_out(int mm);
    longint y;
    y = model_f(mm) - 3 * model_f(mm - 1) + 3 * model_f(mm - 2) - model_f(mm - 3);
    y = y >>> (3 * m_l - 4);
    return y[15:0];
  endfunction

  task automatic model_clear();
    m_x.delete();
    m_pend.delete();
    m_cnt  = 0;
    m_dec  = 0;
    m_hold = 16'h0000;
  endtask

  // One clock: drive inputs, advance model at the edge, compare #1 later.
  task automatic tick(input logic nd_v, input logic [11:0] din_v, input logic sclr_v,
                      input logic we_v, input logic [12:0] rate_v,
                      output logic r_o, output logic [15:0] d_o);
    pend_t p;
    nd      = nd_v;
    din     = din_v;
    sclr    = sclr_v;
    rate_we = we_v;
    rate    = rate_v;
    @(posedge clk);
    cyc++;
    if (sclr_v || we_v) begin
      if (we_v) begin
        if (rate_v < 13'd4)         m_r = 4;
        else if (rate_v > 13'd4096) m_r = 4096;
        else                        m_r = int'(rate_v);
        m_l = $clog2(m_r);
      end
      model_clear();
    end else if (nd_v && m_rfd) begin
      m_x.push_back(int'($signed(din_v)));
      m_cnt++;
      if (m_cnt == m_r) begin
        m_cnt = 0;
        m_dec++;
        p.due = cyc + 4;
        p.val = model_out(m_dec);
        m_pend.push_back(p);
      end
    end
    m_rfd = 1'b1;
    #1;
    check("rfd", rfd, m_rfd);
    if (m_pend.size() > 0 && m_pend[0].due == cyc) begin
      check("rdy_strobe", rdy, 1);
      check("dout_value", dout, m_pend[0].val);
      m_hold = m_pend[0].val;
      void'(m_pend.pop_front());
    end else begin
      check("rdy_idle", rdy, 0);
      check("dout_hold", dout, m_hold);
    end
    r_o = rdy;
    d_o = dout;
  endtask

  typedef struct {
    logic [12:0] rate;
    logic [11:0] din;
    int          period;
    int          frames;
    int          exp_r;
    logic [15:0] exp_dout;
  } vec_t;

  vec_t        vecs[6];
  logic        r;
  logic [15:0] d;
  int          rdy_cnt;
  longint      last_t;
  int          first_c;
  int          total;
  int          duty;
  int          rand_rdys;

  initial begin
    vecs[0] = '{13'd4,    12'h010, 4, 6, 4,    16'h0100};
    vecs[1] = '{13'd64,   12'h7FF, 1, 5, 64,   16'h7FF0};
    vecs[2] = '{13'd64,   12'h800, 1, 5, 64,   16'h8000};
    vecs[3] = '{13'd5,    12'h100, 1, 6, 5,    16'h03E8};
    vecs[4] = '{13'd2,    12'h010, 1, 6, 4,    16'h0100};
    vecs[5] = '{13'd5000, 12'h001, 1, 4, 4096, 16'h0010};

    // Reset state
    reset_n = 1'b0;
    sclr    = 1'b0;
    nd      = 1'b0;
    din     = 12'h000;
    rate_we = 1'b0;
    rate    = 13'd0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_rfd", rfd, 0);
    check("reset_rdy", rdy, 0);
    check("reset_dout", dout, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // nd on the first edge after release is ignored; default R=4 then applies.
    tick(1'b1, 12'h7FF, 1'b0, 1'b0, 13'd0, r, d);
    rdy_cnt = 0;
    first_c = -1;
    for (int c = 0; c < 22; c++) begin
      tick(c < 16, 12'h010, 1'b0, 1'b0, 13'd0, r, d);
      if (r) begin
        rdy_cnt++;
        if (first_c < 0) first_c = c;
        if (rdy_cnt == 4) check("default_r4_steady", d, 16'h0100);
      end
    end
    check("default_r4_first_rdy", first_c, 7);
    check("default_r4_rdy_count", rdy_cnt, 4);

    // Table of constant-input rate cases
    foreach (vecs[v]) begin
      tick(1'b0, vecs[v].din, 1'b0, 1'b1, vecs[v].rate, r, d);
      total   = vecs[v].frames * vecs[v].exp_r * vecs[v].period + 6;
      rdy_cnt = 0;
      last_t  = -1;
      for (int c = 0; c < total; c++) begin
        tick((c % vecs[v].period) == 0, vecs[v].din, 1'b0, 1'b0, 13'd0, r, d);
        if (r) begin
          rdy_cnt++;
          if (last_t >= 0) check("rdy_spacing", c - last_t, vecs[v].exp_r * vecs[v].period);
          last_t = c;
          if (rdy_cnt >= 4) check("steady_dout", d, vecs[v].exp_dout);
        end
      end
      check("rdy_count", rdy_cnt, vecs[v].frames);
    end

    // sclr mid-frame: outputs cleared, R=5 retained
    tick(1'b0, 12'h010, 1'b0, 1'b1, 13'd5, r, d);
    for (int c = 0; c < 16; c++) tick(1'b1, 12'h010, 1'b0, 1'b0, 13'd0, r, d);
    tick(1'b1, 12'h010, 1'b1, 1'b0, 13'd0, r, d);
    check("sclr_rdy", r, 0);
    check("sclr_dout", d, 0);
    first_c = -1;
    for (int c = 0; c < 20; c++) begin
      tick(1'b1, 12'h010, 1'b0, 1'b0, 13'd0, r, d);
      if (r && first_c < 0) first_c = c;
    end
    check("post_sclr_first_rdy", first_c, 8);

    // rate_we coinciding with nd: that sample is discarded
    tick(1'b1, 12'h7FF, 1'b0, 1'b1, 13'd4, r, d);
    first_c = -1;
    for (int c = 0; c < 12; c++) begin
      tick(1'b1, 12'h010, 1'b0, 1'b0, 13'd0, r, d);
      if (r && first_c < 0) first_c = c;
    end
    check("rate_we_nd_first_rdy", first_c, 7);

    // Asynchronous reset mid-operation
    tick(1'b0, 12'h000, 1'b0, 1'b1, 13'd5, r, d);
    for (int c = 0; c < 14; c++) tick(1'b1, 12'h123, 1'b0, 1'b0, 13'd0, r, d);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst_rfd", rfd, 0);
    check("async_rst_rdy", rdy, 0);
    check("async_rst_dout", dout, 0);
    m_r   = 4;
    m_l   = 2;
    m_rfd = 1'b0;
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    first_c = -1;
    for (int c = 0; c < 14; c++) begin
      tick(1'b1, 12'h020, 1'b0, 1'b0, 13'd0, r, d);
      if (r && first_c < 0) first_c = c;
    end
    check("post_reset_first_rdy", first_c, 8);

    // Randomised traffic against the model
    tick(1'b0, 12'h000, 1'b0, 1'b1, 13'd7, r, d);
    duty      = 100;
    rand_rdys = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 500 == 0) duty = int'($urandom_range(30, 100));
      if ($urandom_range(0, 249) == 0) begin
        tick(1'($urandom_range(0, 1)), 12'($urandom), 1'b0, 1'b1,
             13'($urandom_range(0, 48)), r, d);
      end else if ($urandom_range(0, 399) == 0) begin
        tick(1'($urandom_range(0, 1)), 12'($urandom), 1'b1, 1'b0, 13'd0, r, d);
      end else begin
        tick(int'($urandom_range(0, 99)) < duty, 12'($urandom), 1'b0, 1'b0, 13'd0, r, d);
      end
      if (r) rand_rdys++;
    end
    check("random_rdy_seen", rand_rdys > 0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
